// File: rtl/mem_access_pkg.sv
// Shared types and constants for the two-port memory access controller.
package mem_access_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 8;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_ACK     = 3'd4,
        ST_CLEAR   = 3'd5
    } state_t;

    // Port index (0 = A, 1 = B) of a one-hot two-way grant.
    function automatic logic grant_port(input logic [1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer advances on update.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic ptr_r;

    // Grant decode; a lone requester wins regardless of the pointer.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_r ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Pointer register; ptr_r = 0 favours port A.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= 1'b0;
        end else if (update && (grant != 2'b00)) begin
            ptr_r <= grant[0];
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Two-requester controller sequencing setup/strobe/release accesses to the latch memory.
// Optional power-up clear of the whole array when MEM_ACCESS_CTRL_INIT_CLEAR_EN is defined.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int STROBE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_op,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_STB = CNT_W'(STROBE_CYCLES - 1);
`ifdef MEM_ACCESS_CTRL_INIT_CLEAR_EN
    localparam logic [CNT_W-1:0] CLR_STB_END = CNT_W'(STROBE_CYCLES);
    localparam logic [CNT_W-1:0] CLR_LAST    = CNT_W'(STROBE_CYCLES + 1);
    logic clr_pend_r, clr_pend_s;
`endif

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              port_r, port_s;
    logic              we_r, we_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [DATA_W-1:0] wdata_r, wdata_s;
    logic [DATA_W-1:0] a_rdata_r, a_rdata_s;
    logic [DATA_W-1:0] b_rdata_r, b_rdata_s;
    logic              a_ack_r, a_ack_s;
    logic              b_ack_r, b_ack_s;
    logic              busy_r, busy_s;
    logic              mem_op_r, mem_op_s;
    logic              mem_sel_r, mem_sel_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
    logic [1:0]        grant_s;
    logic              arb_upd_s;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({b_req, a_req}),
        .update (arb_upd_s),
        .grant  (grant_s)
    );

    // Next-state, command latch and read-data capture.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        port_s    = port_r;
        we_s      = we_r;
        addr_s    = addr_r;
        wdata_s   = wdata_r;
        a_rdata_s = a_rdata_r;
        b_rdata_s = b_rdata_r;
        arb_upd_s = 1'b0;
`ifdef MEM_ACCESS_CTRL_INIT_CLEAR_EN
        clr_pend_s = clr_pend_r;
`endif
        case (state_r)
            ST_IDLE: begin
`ifdef MEM_ACCESS_CTRL_INIT_CLEAR_EN
                if (clr_pend_r) begin
                    state_s    = ST_CLEAR;
                    cnt_s      = 4'd0;
                    we_s       = OP_WRITE;
                    addr_s     = '0;
                    wdata_s    = '0;
                    clr_pend_s = 1'b0;
                end else
`endif
                if (grant_s != 2'b00) begin
                    arb_upd_s = 1'b1;
                    state_s   = ST_SETUP;
                    port_s    = grant_port(grant_s);
                    we_s      = grant_s[1] ? b_we    : a_we;
                    addr_s    = grant_s[1] ? b_addr  : a_addr;
                    wdata_s   = grant_s[1] ? b_wdata : a_wdata;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s = ST_STROBE;
                cnt_s   = 4'd0;
            end
            ST_STROBE: begin
                if (cnt_r == LAST_STB) begin
                    state_s = ST_RELEASE;
                    if (we_r == OP_READ) begin
                        if (port_r) begin
                            b_rdata_s = mem_rdata;
                        end else begin
                            a_rdata_s = mem_rdata;
                        end
                    end else begin
                        a_rdata_s = a_rdata_r;
                    end
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            ST_RELEASE: state_s = ST_ACK;
            ST_ACK:     state_s = ST_IDLE;
`ifdef MEM_ACCESS_CTRL_INIT_CLEAR_EN
            // Each cleared word: cnt 0 = setup, 1..STROBE_CYCLES = strobe, last = release.
            ST_CLEAR: begin
                if (cnt_r == CLR_LAST) begin
                    if (addr_r == {ADDR_W{1'b1}}) begin
                        state_s = ST_IDLE;
                    end else begin
                        addr_s = addr_r + 1'b1;
                        cnt_s  = 4'd0;
                    end
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
`endif
            default: state_s = ST_IDLE;
        endcase
    end

    // Output values for the state being entered, so every output comes from a flop.
    always_comb begin
        busy_s  = (state_s != ST_IDLE);
        a_ack_s = (state_s == ST_ACK) && (port_s == 1'b0);
        b_ack_s = (state_s == ST_ACK) && (port_s == 1'b1);
        if (busy_s) begin
            mem_op_s    = we_s;
            mem_addr_s  = addr_s;
            mem_wdata_s = wdata_s;
        end else begin
            mem_op_s    = 1'b0;
            mem_addr_s  = '0;
            mem_wdata_s = '0;
        end
        if (state_s == ST_STROBE) begin
            mem_sel_s = 1'b1;
`ifdef MEM_ACCESS_CTRL_INIT_CLEAR_EN
        end else if (state_s == ST_CLEAR) begin
            mem_sel_s = (cnt_s >= 4'd1) && (cnt_s <= CLR_STB_END);
`endif
        end else begin
            mem_sel_s = 1'b0;
        end
    end

    // State, command and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            port_r      <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= '0;
            a_rdata_r   <= '0;
            b_rdata_r   <= '0;
            a_ack_r     <= 1'b0;
            b_ack_r     <= 1'b0;
            busy_r      <= 1'b0;
            mem_op_r    <= 1'b0;
            mem_sel_r   <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
`ifdef MEM_ACCESS_CTRL_INIT_CLEAR_EN
            clr_pend_r  <= 1'b1;
`endif
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            port_r      <= port_s;
            we_r        <= we_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            a_rdata_r   <= a_rdata_s;
            b_rdata_r   <= b_rdata_s;
            a_ack_r     <= a_ack_s;
            b_ack_r     <= b_ack_s;
            busy_r      <= busy_s;
            mem_op_r    <= mem_op_s;
            mem_sel_r   <= mem_sel_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
`ifdef MEM_ACCESS_CTRL_INIT_CLEAR_EN
            clr_pend_r  <= clr_pend_s;
`endif
        end
    end

    assign a_ack     = a_ack_r;
    assign b_ack     = b_ack_r;
    assign a_rdata   = a_rdata_r;
    assign b_rdata   = b_rdata_r;
    assign busy      = busy_r;
    assign mem_op    = mem_op_r;
    assign mem_sel   = mem_sel_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule
